button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 173 +++++++++++++++++
 tb/tb_button_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop synchroniser, counter-based debouncer,
// registered press/release edge pulses and an optional hold-to-repeat pulse
// generator. Define BTN_AUTOREPEAT_EN to build the repeat FSMs and timers;
// without it repeat_o is tied low and everything else is identical.
// Ports carry _i/_o suffixes because "release" and "repeat" are reserved words.
module button_conditioner #(
   parameter int unsigned N_CH            = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic [N_CH-1:0] noisy_i,
   output logic [N_CH-1:0] clean_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] repeat_o,
   output logic            any_event_o
);

   localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0] sync1_q, sync2_q;
   logic [23:0]     cnt_q [N_CH];
   logic [23:0]     cnt_d [N_CH];
   logic [N_CH-1:0] clean_q, clean_d;
   logic [N_CH-1:0] press_q, press_d;
   logic [N_CH-1:0] release_q, release_d;
   logic            any_q, any_d;

   // Two-stage synchroniser for the asynchronous button levels
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= noisy_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive mismatches, toggle clean on the last one
   always_comb begin
      clean_d = clean_q;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               clean_d[i] = ~clean_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 24'd1;
            end
         end
      end
      press_d   = clean_d & ~clean_q;
      release_d = ~clean_d & clean_q;
      any_d     = |(press_d | release_d);
   end

   // Debounce state and registered edge pulses
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
         clean_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         any_q     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         clean_q   <= clean_d;
         press_q   <= press_d;
         release_q <= release_d;
         any_q     <= any_d;
      end
   end

   assign clean_o     = clean_q;
   assign press_o     = press_q;
   assign release_o   = release_q;
   assign any_event_o = any_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rpt_state_e;

   rpt_state_e      st_q  [N_CH];
   rpt_state_e      st_d  [N_CH];
   logic [31:0]     tmr_q [N_CH];
   logic [31:0]     tmr_d [N_CH];
   logic [N_CH-1:0] repeat_q, repeat_d;

   // Repeat FSM keys off next-cycle clean/press so pulses line up with the
   // registered press/release outputs and never overlap them
   always_comb begin
      repeat_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         st_d[i]  = st_q[i];
         tmr_d[i] = tmr_q[i];
         if (!clean_d[i]) begin
            st_d[i]  = IDLE;
            tmr_d[i] = '0;
         end else begin
            case (st_q[i])
               IDLE: begin
                  if (press_d[i]) begin
                     st_d[i]  = DELAY;
                     tmr_d[i] = '0;
                  end
               end
               DELAY: begin
                  if (tmr_q[i] == RD_LAST) begin
                     st_d[i]     = RPT;
                     tmr_d[i]    = '0;
                     repeat_d[i] = 1'b1;
                  end else begin
                     tmr_d[i] = tmr_q[i] + 32'd1;
                  end
               end
               RPT: begin
                  if (tmr_q[i] == RP_LAST) begin
                     tmr_d[i]    = '0;
                     repeat_d[i] = 1'b1;
                  end else begin
                     tmr_d[i] = tmr_q[i] + 32'd1;
                  end
               end
               default: begin
                  st_d[i]  = IDLE;
                  tmr_d[i] = '0;
               end
            endcase
         end
      end
   end

   // Repeat FSM state, timers and registered repeat pulse
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            st_q[i]  <= IDLE;
            tmr_q[i] <= '0;
         end
         repeat_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_d[i];
            tmr_q[i] <= tmr_d[i];
         end
         repeat_q <= repeat_d;
      end
   end

   assign repeat_o = repeat_q;
`else
   // Repeat timing parameters have no effect in this build
   if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_rpt_cfg_unused
   end

   assign repeat_o = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with N_CH=3,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] noisy;
   logic [2:0] clean, press, rel, rpt;
   logic       any_event;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_CH           (3),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) dut (
      .clk_i      (clk),
      .resetn_i   (resetn),
      .noisy_i    (noisy),
      .clean_o    (clean),
      .press_o    (press),
      .release_o  (rel),
      .repeat_o   (rpt),
      .any_event_o(any_event)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] c, input logic [2:0] p,
                             input logic [2:0] r, input logic [2:0] rp, input logic a);
      check({tag, ".clean"},   32'(clean),     32'(c));
      check({tag, ".press"},   32'(press),     32'(p));
      check({tag, ".release"}, 32'(rel),       32'(r));
      check({tag, ".repeat"},  32'(rpt),       32'(rp));
      check({tag, ".any"},     32'(any_event), 32'(a));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rep_exp;
      logic [2:0] clean_exp;
      logic [2:0] rel_exp;

      resetn = 1'b0;
      noisy  = 3'b000;
      #23;
      expect_out("reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      step();
      resetn = 1'b1;
      step();
      step();
      expect_out("idle", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

      // Single channel press: clean/press exactly 6 edges after the level change
      noisy = 3'b001;
      for (int k = 1; k <= 5; k++) begin
         step();
         expect_out("t1_wait", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      end
      step();
      expect_out("t1_press", 3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
      step();
      expect_out("t1_after", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
      noisy = 3'b000;
      for (int k = 1; k <= 5; k++) begin
         step();
         expect_out("t1_rwait", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
      end
      step();
      expect_out("t1_release", 3'b000, 3'b000, 3'b001, 3'b000, 1'b1);
      step();
      expect_out("t1_rafter", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

      // Short glitch on channel 1 is rejected
      noisy = 3'b010;
      step();
      step();
      step();
      noisy = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         step();
         expect_out("t2_glitch", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      end
      // Counter restarted: a real press again needs the full 6 edges
      noisy = 3'b010;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("t2_rwait.press", 32'(press), 32'(3'b000));
      end
      step();
      expect_out("t2_press", 3'b010, 3'b010, 3'b000, 3'b000, 1'b1);
      noisy = 3'b000;
      for (int k = 1; k <= 6; k++) step();
      expect_out("t2_release", 3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
      step();

      // Simultaneous channels
      noisy = 3'b101;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("t3_wait.press", 32'(press), 32'(3'b000));
      end
      step();
      expect_out("t3_press", 3'b101, 3'b101, 3'b000, 3'b000, 1'b1);
      step();
      expect_out("t3_after", 3'b101, 3'b000, 3'b000, 3'b000, 1'b0);
      noisy = 3'b000;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("t3_rwait.release", 32'(rel), 32'(3'b000));
      end
      step();
      expect_out("t3_release", 3'b000, 3'b000, 3'b101, 3'b000, 1'b1);
      step();

      // Hold channel 2: repeat at 10,13,..,28 after press; release at 30
      noisy = 3'b100;
      for (int k = 1; k <= 5; k++) step();
      step();
      expect_out("t4_press", 3'b100, 3'b100, 3'b000, 3'b000, 1'b1);
      for (int k = 1; k <= 35; k++) begin
         step();
`ifdef BTN_AUTOREPEAT_EN
         rep_exp = (k >= 10 && k <= 28 && ((k - 10) % 3) == 0) ? 3'b100 : 3'b000;
`else
         rep_exp = 3'b000;
`endif
         clean_exp = (k < 30) ? 3'b100 : 3'b000;
         rel_exp   = (k == 30) ? 3'b100 : 3'b000;
         expect_out($sformatf("t4_k%0d", k), clean_exp, 3'b000, rel_exp, rep_exp, (k == 30));
         if (k == 24) noisy = 3'b000;
      end

      // Reset while channel 0 counter is at 2 and channel 2 is held
      noisy = 3'b100;
      for (int k = 1; k <= 5; k++) step();
      step();
      check("t5_pre.press", 32'(press), 32'(3'b100));
      noisy = 3'b101;
      for (int k = 1; k <= 4; k++) step();
      expect_out("t5_before", 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
      resetn = 1'b0;
      #1;
      expect_out("t5_in_reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      step();
      expect_out("t5_held_reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      resetn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         expect_out("t5_wait", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      end
      step();
      expect_out("t5_press", 3'b101, 3'b101, 3'b000, 3'b000, 1'b1);
      step();
      expect_out("t5_after", 3'b101, 3'b000, 3'b000, 3'b000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
